// File: rtl/output_arbiter_if.sv
// Output-port arbiter bus definitions.
// output_arbiter_pkg holds the port identifier type shared by the arbiter
// and its requesters; output_arbiter_if bundles the request/grant signals.
//
// Handshake: grant_o[i] is a read strobe. Buffer i presents a flit by holding
// request_i[i] (with out_port_i[i] and last_i[i] describing its head flit).
// The flit moves in every cycle where request_i[i] and grant_o[i] are both 1
// at the rising edge of clk. A grant is only ever given while
// downstream_on_i=1, so the downstream buffer never sees a flit without space.

package output_arbiter_pkg;

  // Router port identifiers; the arbiter compares out_port_i against MY_PORT.
  typedef enum logic [2:0] {
    DLA0 = 3'd0,
    DLA1 = 3'd1,
    DLA2 = 3'd2,
    CPU0 = 3'd3,
    MEM0 = 3'd4
  } port_t;

endpackage : output_arbiter_pkg

interface output_arbiter_if
  import output_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 5
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester side
  logic [NUM_REQ-1:0] request_i;
  port_t              out_port_i [NUM_REQ];
  logic [NUM_REQ-1:0] last_i;
  logic               downstream_on_i;

  // Arbiter side
  logic [NUM_REQ-1:0] grant_o;
  logic [IDX_W-1:0]   grant_idx_o;
  logic               busy_o;
  logic               timeout_o;
  logic               dbg_state_o;   // raw FSM state: 0 = IDLE, 1 = LOCKED

  // Requesters / surrounding router logic
  modport master (
    output request_i,
    output out_port_i,
    output last_i,
    output downstream_on_i,
    input  grant_o,
    input  grant_idx_o,
    input  busy_o,
    input  timeout_o,
    input  dbg_state_o
  );

  // The arbiter itself
  modport slave (
    input  request_i,
    input  out_port_i,
    input  last_i,
    input  downstream_on_i,
    output grant_o,
    output grant_idx_o,
    output busy_o,
    output timeout_o,
    output dbg_state_o
  );

endinterface : output_arbiter_if

// File: rtl/output_arbiter.sv
// Wormhole output-port arbiter.
// Picks one of NUM_REQ input buffers heading for MY_PORT with a round-robin
// search, then locks the port to that owner until its TAIL flit is granted.
// Single-flit packets (HEADTAIL) are granted from IDLE without locking.
// Optional build macro ARB_WATCHDOG_EN adds a stall watchdog that raises the
// sticky timeout_o after WD_LIMIT consecutive grantless LOCKED cycles; without
// it timeout_o is tied to 0 and no counter exists.

module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter int    NUM_REQ  = 5,
  parameter port_t MY_PORT  = DLA0,
  parameter int    WD_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst,   // synchronous, active-low
  output_arbiter_if.slave     bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;

  logic [NUM_REQ-1:0] eligible;
  logic               any_eligible;
  logic [IDX_W-1:0]   rr_winner;
  logic               owner_req;
  logic               owner_last;
  logic [NUM_REQ-1:0] grant;
  logic               grant_fire;

  // First set bit of elig searching ptr+1, ptr+2, ... wrapping at NUM_REQ.
  // Returns 0 when nothing is set; callers qualify with |elig.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] elig,
    input logic [IDX_W-1:0]   ptr
  );
    logic [IDX_W-1:0] pick;
    logic             found;
    int               cand;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!found && elig[IDX_W'(cand)]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
    return pick;
  endfunction

  // Eligibility: requesting and headed for this output port.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.request_i[i] && (bus.out_port_i[i] == MY_PORT);
    end
  end

  assign any_eligible = |eligible;
  assign rr_winner    = rr_pick(eligible, ptr_q);
  assign owner_req    = bus.request_i[owner_q];
  assign owner_last   = bus.last_i[owner_q];

  // State register: FSM state, packet owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic. Nothing moves while the downstream buffer is full,
  // and a LOCKED owner with an empty buffer simply waits.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_eligible && bus.downstream_on_i) begin
          // owner also tracks single-flit winners so grant_idx_o shows them.
          owner_d = rr_winner;
          if (bus.last_i[rr_winner]) begin
            ptr_d = rr_winner;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (owner_req && bus.downstream_on_i && owner_last) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: combinational grant, held at zero while reset is asserted.
  always_comb begin
    grant = '0;
    if (rst && bus.downstream_on_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_eligible) begin
            grant[rr_winner] = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (owner_req) begin
            grant[owner_q] = 1'b1;
          end
        end
        default: begin
          grant = '0;
        end
      endcase
    end
  end

  assign grant_fire      = |grant;
  assign bus.grant_o     = grant;
  assign bus.grant_idx_o = owner_q;
  assign bus.busy_o      = (state_q == ST_LOCKED);
  assign bus.dbg_state_o = state_q;

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  // Watchdog next-state: count grantless LOCKED cycles, saturate, latch flag.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if ((state_q != ST_LOCKED) || grant_fire) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_W'(WD_LIMIT)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    if (wd_cnt_d == WD_W'(WD_LIMIT)) begin
      timeout_d = 1'b1;
    end
  end

  // Watchdog registers; the timeout flag only clears on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  logic unused_wd;
  assign unused_wd     = grant_fire & (WD_LIMIT > 0);
  assign bus.timeout_o = 1'b0;
`endif

endmodule : output_arbiter

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter (NUM_REQ=5, MY_PORT=DLA0, WD_LIMIT=16).
// The driver applies one input vector per cycle and queues the outputs that
// cycle must show; a monitor on the falling edge pops and compares them.

module tb_output_arbiter;
  import output_arbiter_pkg::*;

  localparam int N = 5;
  localparam int W = N + 1 + 3 + 1;   // {grant, busy, idx, timeout}

`ifdef ARB_WATCHDOG_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  output_arbiter_if #(.NUM_REQ(N)) bus ();

  output_arbiter #(
    .NUM_REQ (N),
    .MY_PORT (DLA0),
    .WD_LIMIT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         chk_pending = 1'b0;
  logic         end_req  = 1'b0;
  logic         end_done = 1'b0;

  // Driver tasks
  task automatic apply(input logic rst_n, input logic [N-1:0] req,
                       input logic [N-1:0] mine, input logic [N-1:0] last,
                       input logic on);
    rst           = rst_n;
    bus.request_i = req;
    for (int i = 0; i < N; i++) begin
      bus.out_port_i[i] = mine[i] ? DLA0 : DLA1;
    end
    bus.last_i          = last;
    bus.downstream_on_i = on;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk_pending = 1'b0;
  endtask

  task automatic step(input string nm, input logic rst_n,
                      input logic [N-1:0] req, input logic [N-1:0] mine,
                      input logic [N-1:0] last, input logic on,
                      input logic [N-1:0] g, input logic b,
                      input logic [2:0] idx, input logic t);
    apply(rst_n, req, mine, last, on);
    exp_q.push_back({g, b, idx, t});
    name_q.push_back(nm);
    chk_pending = 1'b1;
    tick();
  endtask

  // Monitor: compare the DUT outputs of every checked cycle
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        nm;
    if (chk_pending) begin
      got = {bus.grant_o, bus.busy_o, bus.grant_idx_o, bus.timeout_o};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: output seen with empty expected queue, got %b", got);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL %s: got grant=%b busy=%b idx=%0d tmo=%b, expected grant=%b busy=%b idx=%0d tmo=%b",
                   nm, got[9:5], got[4], got[3:1], got[0],
                   exp[9:5], exp[4], exp[3:1], exp[0]);
        end
      end
    end else if (end_req && !end_done) begin
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  // Stimulus
  initial begin
    apply(1'b0, '0, '1, '1, 1'b1);
    tick();

    // Reset holds grants at zero even with everyone requesting
    step("reset", 0, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd0, 0);

    // Round-robin among single-flit requesters 1 and 2
    step("rr_a",    1, 5'b00110, 5'b11111, 5'b11111, 1, 5'b00010, 0, 3'd0, 0);
    step("rr_b",    1, 5'b00110, 5'b11111, 5'b11111, 1, 5'b00100, 0, 3'd1, 0);
    step("rr_c",    1, 5'b00110, 5'b11111, 5'b11111, 1, 5'b00010, 0, 3'd2, 0);
    step("rr_idle", 1, 5'b00000, 5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd1, 0);

    // Fresh reset, then a 3-flit packet from 0 while 3 waits
    apply(1'b0, '0, '1, '0, 1'b1);
    tick();
    step("pkt_head",  1, 5'b01001, 5'b11111, 5'b00000, 1, 5'b00001, 0, 3'd0, 0);
    step("pkt_body",  1, 5'b01001, 5'b11111, 5'b00000, 1, 5'b00001, 1, 3'd0, 0);
    step("pkt_tail",  1, 5'b01001, 5'b11111, 5'b00001, 1, 5'b00001, 1, 3'd0, 0);
    step("pkt_next",  1, 5'b01001, 5'b11111, 5'b01000, 1, 5'b01000, 0, 3'd0, 0);
    step("pkt_quiet", 1, 5'b00000, 5'b11111, 5'b00000, 1, 5'b00000, 0, 3'd3, 0);

    // Requester 1 targets another port: only 2 is granted
    step("port_a", 1, 5'b00110, 5'b11101, 5'b11111, 1, 5'b00100, 0, 3'd3, 0);
    step("port_b", 1, 5'b00110, 5'b11101, 5'b11111, 1, 5'b00100, 0, 3'd2, 0);
    step("port_c", 1, 5'b00110, 5'b11101, 5'b11111, 1, 5'b00100, 0, 3'd2, 0);

    // Lock on owner 2, downstream off for 4 cycles, then resume
    step("lock2", 1, 5'b00100, 5'b11111, 5'b00000, 1, 5'b00100, 0, 3'd2, 0);
    for (int k = 0; k < 4; k++) begin
      step("off_hold", 1, 5'b00110, 5'b11111, 5'b00000, 0, 5'b00000, 1, 3'd2, 0);
    end
    step("on_resume", 1, 5'b00110, 5'b11111, 5'b00000, 1, 5'b00100, 1, 3'd2, 0);

    // Owner buffer empty: no grant, other requester stays blocked
    for (int k = 1; k <= 18; k++) begin
      step("wd_stall", 1, 5'b00010, 5'b11111, 5'b00000, 1, 5'b00000, 1, 3'd2,
           WD_ON && (k >= 17));
    end
    step("wd_tail",   1, 5'b00100, 5'b11111, 5'b00100, 1, 5'b00100, 1, 3'd2, WD_ON);
    step("wd_sticky", 1, 5'b00000, 5'b11111, 5'b00000, 1, 5'b00000, 0, 3'd2, WD_ON);

    // Lock on owner 4, reset mid-packet, then 0 wins over 4
    step("lock4",     1, 5'b10000, 5'b11111, 5'b00000, 1, 5'b10000, 0, 3'd2, WD_ON);
    step("rst_mid",   0, 5'b10001, 5'b11111, 5'b00000, 1, 5'b00000, 1, 3'd4, WD_ON);
    step("post_rst0", 1, 5'b10001, 5'b11111, 5'b11111, 1, 5'b00001, 0, 3'd0, 0);
    step("post_rst4", 1, 5'b10001, 5'b11111, 5'b11111, 1, 5'b10000, 0, 3'd0, 0);
    step("idle_off",  1, 5'b11111, 5'b11111, 5'b11111, 0, 5'b00000, 0, 3'd4, 0);

    // Queue must be fully drained
    end_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_output_arbiter

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 5: number of input-port requesters competing for this output port.
REQ-002 Parameter MY_PORT, default DLA0 (port_t): the output port this arbiter serves.
REQ-003 Parameter WD_LIMIT, default 16: watchdog stall threshold in cycles; used only under REQ-024.
REQ-004 clk  input  1  single clock; every register updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-low, sampled only on the rising edge of clk.
REQ-006 request_i  input  NUM_REQ  switch request from each input buffer.
REQ-007 out_port_i  input  NUM_REQ x port_t  next-hop port held by each input buffer.
REQ-008 last_i  input  NUM_REQ  the head flit of buffer i is TAIL or HEADTAIL.
REQ-009 downstream_on_i  input  1  on/off credit from the downstream buffer; 1 means space is available.
REQ-010 grant_o  output  NUM_REQ  one-hot or zero; drives read_i of the granted buffer.
REQ-011 grant_idx_o  output  $clog2(NUM_REQ)  index of the current or last owner.
REQ-012 busy_o  output  1  a packet is locked to an owner.
REQ-013 timeout_o  output  1  sticky watchdog flag.

Function
REQ-014 A requester is eligible when request_i[i]=1 and out_port_i[i]==MY_PORT.
REQ-015 The FSM has two states, IDLE and LOCKED, and an owner register.
- Round-robin pointer ptr resets to NUM_REQ-1.
REQ-016 IDLE: if any requester is eligible and downstream_on_i=1, grant the first eligible index searching ptr+1, ptr+2, ... modulo NUM_REQ.
- The grant is combinational, in the same cycle.
REQ-017 IDLE grant with last_i[winner]=1 (single-flit packet): stay in IDLE and set ptr to the winner.
- Otherwise go to LOCKED with owner set to the winner.
REQ-018 LOCKED: grant_o[owner] = request_i[owner] & downstream_on_i; every other grant bit is 0.
- Other requesters are never granted mid-packet.
REQ-019 LOCKED grant with last_i[owner]=1: go to IDLE, set ptr to owner, and free the port the next cycle.
- The new round-robin search starts at owner+1.
REQ-020 If downstream_on_i=0, grant_o is all zero in every state; state, owner and ptr hold.
REQ-021 In LOCKED, request_i[owner]=0 (buffer momentarily empty) produces no grant and no state change.
REQ-022 busy_o = (state==LOCKED); grant_idx_o is the owner register.
- In IDLE, grant_idx_o shows the last winner.
REQ-023 grant_o never has more than one bit set in any cycle.

Configuration
REQ-024 With ARB_WATCHDOG_EN defined, a counter behaves as follows:
- It increments each LOCKED cycle without a grant and clears on any grant or on entering IDLE.
- It saturates at WD_LIMIT.
- Reaching WD_LIMIT sets timeout_o, which stays set until reset.
- Arbitration behaviour is otherwise unchanged.
REQ-025 Without ARB_WATCHDOG_EN, no counter is built and timeout_o is constant 0.

Reset
REQ-026 With rst=0 at a clock edge, the following values are loaded:
- state = IDLE, owner = 0, ptr = NUM_REQ-1.
- Watchdog counter = 0, timeout_o = 0.
REQ-027 While rst=0, grant_o is all zero regardless of inputs.
REQ-028 Reset asserted mid-packet abandons the lock; the first grant after release follows REQ-016 from ptr = NUM_REQ-1.

Verification
REQ-029 After reset, request_i=5'b00110 with both targeting MY_PORT, on=1, all last_i=1 -> grant_o=00010, then 00100, then 00010.
REQ-030 Requester 0 sends a 3-flit packet (HEAD, BODY, TAIL) while requester 3 is also eligible -> grant_o=00001 for 3 grant cycles, busy_o=1 until the TAIL grant, then 01000.
REQ-031 Requesters 1 and 2 both eligible, but out_port_i[1] != MY_PORT -> only bit 2 is ever granted.
REQ-032 LOCKED on owner 2 with on=0 for 4 cycles -> grant_o=0 and state held; on=1 resumes grant_o=00100.
REQ-033 rst=0 for one cycle while LOCKED on owner 4 -> busy_o=0 next cycle; with 0 and 4 then eligible, 0 wins.
REQ-034 With ARB_WATCHDOG_EN, LOCKED with request_i[owner]=0 for 16 cycles -> timeout_o=1 from cycle 16 and stays 1; without the macro it stays 0.
